// File: rtl/serializer_pkg.sv
// Shared types for the stream blocks: serializer FSM state encoding.
`ifndef SERIALIZER
`define SERIALIZER
package serializer_pkg;

  // Single state bit: IDLE drives o_dv low, SHIFT drives o_dv high.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

endpackage
`endif

// File: rtl/serializer.sv
// Parallel-to-serial converter: one NUM_WORDS*WIDTH word in, NUM_WORDS WIDTH-bit
// words out over a valid/ready stream. A one-entry pending buffer lets the next
// parallel word be captured while the current one drains, so consecutive words
// leave with no bubble.
module serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NUM_WORDS     = 4,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic                       clk,
  input  logic                       i_reset_n,
  input  logic [NUM_WORDS*WIDTH-1:0] i_data,
  input  logic                       i_dv,
  output logic                       o_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_dv,
  input  logic                       i_ready,
  output logic                       o_last
);

  localparam int TOTAL_W = NUM_WORDS * WIDTH;
  localparam int CNT_W   = $clog2(NUM_WORDS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);

  ser_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [TOTAL_W-1:0] shift_q;
  logic [TOTAL_W-1:0] pend_q;
  logic               pend_valid;

  logic accept;
  logic xfer;
  logic cnt_last;
  logic shift_free;

  // Advance the shift register by one serial word, zero-filling the vacated end.
  // LE emits from the bottom so it shifts right; BE emits from the top so it shifts left.
  function automatic logic [TOTAL_W-1:0] shift_next(input logic [TOTAL_W-1:0] cur);
    if (LITTLE_ENDIAN != 0) begin
      return cur >> WIDTH;
    end else begin
      return cur << WIDTH;
    end
  endfunction

  // Handshakes and the point at which the shift register can take a new word.
  assign o_ready    = i_reset_n & ~pend_valid;
  assign accept     = i_dv & o_ready;
  assign o_dv       = (state == S_SHIFT);
  assign xfer       = o_dv & i_ready;
  assign cnt_last   = (cnt == CNT_LAST);
  assign shift_free = (state == S_IDLE) | (xfer & cnt_last);

  assign o_last = o_dv & cnt_last;
  assign o_data = (LITTLE_ENDIAN != 0) ? shift_q[WIDTH-1:0] : shift_q[TOTAL_W-1 -: WIDTH];

  // FSM, word counter, shift register and pending buffer. The pending word has
  // priority for a free shift register; o_ready is low whenever it is occupied,
  // so a new accept can never collide with a pending-to-shift move.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shift_q    <= '0;
      pend_q     <= '0;
      pend_valid <= 1'b0;
    end else if (shift_free) begin
      if (pend_valid) begin
        shift_q    <= pend_q;
        pend_valid <= 1'b0;
        cnt        <= '0;
        state      <= S_SHIFT;
      end else if (accept) begin
        shift_q <= i_data;
        cnt     <= '0;
        state   <= S_SHIFT;
      end else begin
        state <= S_IDLE;
      end
    end else begin
      if (xfer) begin
        cnt     <= cnt + CNT_W'(1);
        shift_q <= shift_next(shift_q);
      end
      if (accept) begin
        pend_q     <= i_data;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: three builds (LE x4, BE x4, LE x1) share one stimulus
// stream and are each scored against a queue-based model of the serial output.
module tb_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dv;
  logic        rdy;
  logic [31:0] din;

  logic [2:0]  ordy, odv, olast;
  logic [7:0]  od0, od1, od2;

  always #5 clk = ~clk;

  serializer #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(1)) u_le (
    .clk(clk), .i_reset_n(rst_n), .i_data(din), .i_dv(dv), .o_ready(ordy[0]),
    .o_data(od0), .o_dv(odv[0]), .i_ready(rdy), .o_last(olast[0]));

  serializer #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(0)) u_be (
    .clk(clk), .i_reset_n(rst_n), .i_data(din), .i_dv(dv), .o_ready(ordy[1]),
    .o_data(od1), .o_dv(odv[1]), .i_ready(rdy), .o_last(olast[1]));

  serializer #(.WIDTH(8), .NUM_WORDS(1), .LITTLE_ENDIAN(1)) u_n1 (
    .clk(clk), .i_reset_n(rst_n), .i_data(din[7:0]), .i_dv(dv), .o_ready(ordy[2]),
    .o_data(od2), .o_dv(odv[2]), .i_ready(rdy), .o_last(olast[2]));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per build, a FIFO of {last, byte} still owed on the output.
  logic [8:0] mq [3][64];
  int  hd [3];
  int  tl [3];
  int  acc_cnt [3];
  int  pop_cnt [3];
  bit  last_acc [3];
  bit  after_rst = 1'b0;
  bit  armed     = 1'b0;

  function automatic int nw(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  // Parallel words held inside the DUT (partially sent one counts as whole).
  function automatic int outst(input int d);
    return (tl[d] - hd[d] + nw(d) - 1) / nw(d);
  endfunction

  function automatic bit mready(input int d);
    return rst_n && (outst(d) < 2);
  endfunction

  task automatic check_outputs();
    logic [7:0] od;
    for (int d = 0; d < 3; d++) begin
      od = (d == 0) ? od0 : (d == 1) ? od1 : od2;
      chk($sformatf("o_ready[%0d]", d), 32'(ordy[d]), 32'(mready(d)));
      chk($sformatf("o_dv[%0d]", d), 32'(odv[d]), 32'(tl[d] != hd[d]));
      if (after_rst) begin
        chk($sformatf("rst_o_data[%0d]", d), 32'(od), 32'd0);
      end
      if (tl[d] != hd[d]) begin
        chk($sformatf("o_data[%0d]", d), 32'(od), 32'(mq[d][hd[d] % 64][7:0]));
        chk($sformatf("o_last[%0d]", d), 32'(olast[d]), 32'(mq[d][hd[d] % 64][8]));
      end else begin
        chk($sformatf("idle_o_last[%0d]", d), 32'(olast[d]), 32'd0);
      end
    end
  endtask

  // Advance the model across the coming posedge using the inputs just driven.
  task automatic model_update();
    bit acc, xf;
    int idx;
    if (!rst_n) begin
      after_rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
        hd[d] = 0; tl[d] = 0; last_acc[d] = 1'b0;
      end
    end else begin
      after_rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
        acc = dv && mready(d);
        xf  = (tl[d] != hd[d]) && rdy;
        last_acc[d] = acc;
        if (xf) begin
          hd[d]++;
          pop_cnt[d]++;
        end
        if (acc) begin
          acc_cnt[d]++;
          for (int k = 0; k < nw(d); k++) begin
            idx = (d == 1) ? (nw(d) - 1 - k) : k;
            mq[d][tl[d] % 64] = {(k == nw(d) - 1), din[idx*8 +: 8]};
            tl[d]++;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] d, input logic rd);
    @(negedge clk);
    if (armed) check_outputs();
    rst_n = r; dv = v; din = d; rdy = rd;
    model_update();
    armed = 1'b1;
  endtask

  logic [31:0] words3 [3];
  int idx3;
  int base;
  int cyc;

  initial begin
    rst_n = 1'b0; dv = 1'b0; din = '0; rdy = 1'b0;
    for (int d = 0; d < 3; d++) begin
      hd[d] = 0; tl[d] = 0; acc_cnt[d] = 0; pop_cnt[d] = 0; last_acc[d] = 1'b0;
    end

    // Reset hold
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Single word, downstream always ready
    step(1'b1, 1'b1, 32'hDDCCBBAA, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Back-to-back words with i_dv held high
    words3[0] = 32'h03020100; words3[1] = 32'h07060504; words3[2] = 32'h0B0A0908;
    idx3 = 0;
    cyc  = 0;
    while (idx3 < 3 && cyc < 40) begin
      step(1'b1, 1'b1, words3[idx3], 1'b1);
      if (last_acc[0]) idx3++;
      cyc++;
    end
    chk("b2b_accepted", 32'(idx3), 32'd3);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Random valid/ready/data, 1000 words through the LE x4 build
    base = acc_cnt[0];
    cyc  = 0;
    while ((acc_cnt[0] - base) < 1000 && cyc < 20000) begin
      step(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("random_words_done", 32'(acc_cnt[0] - base), 32'd1000);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Reset after the second serial word of a word in flight
    cyc = 0;
    step(1'b1, 1'b1, 32'h44332211, 1'b0);
    base = pop_cnt[0];
    while ((pop_cnt[0] - base) < 2 && cyc < 20) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      cyc++;
    end
    chk("pre_reset_pops", 32'(pop_cnt[0] - base), 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1);
    step(1'b1, 1'b1, 32'h88776655, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("post_reset_pops", 32'(pop_cnt[0] - base), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
